// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader
//   Read-side client of the dual-port RAM. Takes a (start address, beat count)
//   command, drives the RAM read port and re-emits the returned words as a
//   valid/ready stream with last-beat marking and a completion pulse.
//
// Ports
//   Clk, Rst            single clock, synchronous active-high reset
//   CmdValid/CmdReady   command handshake; CmdAddr = first word, CmdLen = beats
//   RAddr/REnc          RAM read port; RData returns the cycle after REnc
//   OutValid/OutReady   output stream handshake; OutData, OutLast per beat
//   Done                one-cycle completion pulse
//   DbgState            current FSM state (0 idle, 1 read, 2 drain)
//   BeatCnt, StallCnt   only with DPRAM_STREAM_READER_PERF_EN defined:
//                       saturating counts of transferred beats / stalled cycles
//
// Handshake semantics (both Cmd and Out): a transfer happens on a rising edge
// where valid and ready are both 1. A source holds valid and its payload
// stable until the transfer; ready may change freely.
//
// Optional feature macro: DPRAM_STREAM_READER_PERF_EN.
module dpram_stream_reader #(
  parameter int DataWidth = 64,
  parameter int Depth     = 256,
  parameter int LenWidth  = 16,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 CmdValid,
  output logic                 CmdReady,
  input  logic [AddrWidth-1:0] CmdAddr,
  input  logic [LenWidth-1:0]  CmdLen,
  output logic [AddrWidth-1:0] RAddr,
  output logic                 REnc,
  input  logic [DataWidth-1:0] RData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [DataWidth-1:0] OutData,
  output logic                 OutLast,
  output logic                 Done,
  output logic [1:0]           DbgState
`ifdef DPRAM_STREAM_READER_PERF_EN
  ,
  output logic [31:0]          BeatCnt,
  output logic [31:0]          StallCnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  remain_q;
  logic                 in_flight_q;
  logic                 in_flight_last_q;
  logic                 done_zero_q;

  // 4-entry output FIFO; the last flag travels with each word.
  logic [DataWidth-1:0] fifo_data [4];
  logic [3:0]           fifo_last;
  logic [1:0]           wr_ptr_q;
  logic [1:0]           rd_ptr_q;
  logic [2:0]           occ_q;

  logic cmd_fire;
  logic credit_ok;
  logic issue;
  logic pop;
  logic head_last;
  logic drain_done;

  always_comb begin
    cmd_fire   = CmdValid && (state_q == IDLE);
    // Registered occupancy plus the outstanding read; a pop this cycle does
    // not free a slot until next cycle, so the FIFO can never overflow.
    credit_ok  = ({1'b0, occ_q} + {3'b000, in_flight_q}) <= 4'd2;
    issue      = (state_q == READ) && credit_ok;
    pop        = (occ_q != 3'd0) && OutReady;
    head_last  = fifo_last[rd_ptr_q];
    drain_done = (state_q == DRAIN) && pop && head_last && !in_flight_q;
  end

  // Outputs are gated by Rst so an abort is visible in the reset cycle itself.
  always_comb begin
    CmdReady = (state_q == IDLE) && !Rst;
    REnc     = issue && !Rst;
    RAddr    = Rst ? '0 : addr_q;
    OutValid = (occ_q != 3'd0) && !Rst;
    OutData  = fifo_data[rd_ptr_q];
    OutLast  = OutValid && head_last;
    Done     = !Rst && (done_zero_q || drain_done);
    DbgState = state_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      remain_q         <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      done_zero_q      <= 1'b0;
    end else begin
      done_zero_q      <= 1'b0;
      in_flight_q      <= issue;
      in_flight_last_q <= issue && (remain_q == LenWidth'(1));
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (CmdLen == '0) begin
              done_zero_q <= 1'b1;
            end else begin
              addr_q   <= CmdAddr;
              remain_q <= CmdLen;
              state_q  <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            // Natural power-of-two wrap from Depth-1 back to 0.
            addr_q   <= addr_q + AddrWidth'(1);
            remain_q <= remain_q - LenWidth'(1);
            if (remain_q == LenWidth'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop together leave occ unchanged.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      occ_q     <= 3'd0;
      fifo_last <= 4'd0;
    end else begin
      if (in_flight_q) begin
        fifo_last[wr_ptr_q] <= in_flight_last_q;
        wr_ptr_q            <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({in_flight_q, pop})
        2'b10:   occ_q <= occ_q + 3'd1;
        2'b01:   occ_q <= occ_q - 3'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (in_flight_q) fifo_data[wr_ptr_q] <= RData;
  end

`ifdef DPRAM_STREAM_READER_PERF_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      BeatCnt  <= 32'd0;
      StallCnt <= 32'd0;
    end else begin
      if (OutValid && OutReady && (BeatCnt != 32'hFFFF_FFFF))
        BeatCnt <= BeatCnt + 32'd1;
      if (OutValid && !OutReady && (StallCnt != 32'hFFFF_FFFF))
        StallCnt <= StallCnt + 32'd1;
    end
  end
`endif

endmodule
